// File: rtl/button_pulser_pkg.sv
// Shared types and default timing constants for the button conditioner.
// Defaults assume a 100 MHz system clock.
package button_pulser_pkg;

    typedef enum logic [1:0] {
        S_UP,
        S_DELAY,
        S_REPEAT
    } hold_state_e;

    // 10 ms debounce, 0.5 s initial repeat delay, 0.1 s repeat period.
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_pulser_ch.sv
// One button channel: two-flop synchroniser, counter debouncer, edge pulses
// and a hold-to-repeat FSM. Every output is a register.
module button_pulser_ch
    import button_pulser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,  // "release" is a reserved word
    output logic rpt,
    output logic pulse
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_DELAY   = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_PERIOD  = HOLD_W'(REPEAT_PERIOD);
    localparam logic [HOLD_W-1:0] HOLD_ONE     = HOLD_W'(1);

    logic              s1, s2;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    hold_state_e       state_q, state_d;

    logic level_d, press_d, release_d, rpt_d, pulse_d;
    logic rise, fall, rpt_fire;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others; blocking here would skew the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            cnt_q         <= '0;
            hold_q        <= '0;
            state_q       <= S_UP;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            rpt           <= 1'b0;
            pulse         <= 1'b0;
        end else begin
            s1            <= in;
            s2            <= s1;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            state_q       <= state_d;
            level         <= level_d;
            press         <= press_d;
            release_pulse <= release_d;
            rpt           <= rpt_d;
            pulse         <= pulse_d;
        end
    end

    // Debouncer: any sample matching the current level restarts the count.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        cnt_d   = cnt_q;
        level_d = level;
        rise    = 1'b0;
        fall    = 1'b0;
        if (s2 == level) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s2;
            cnt_d   = '0;
            rise    = s2;
            fall    = ~s2;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Hold FSM: counting runs regardless of repeat_en so re-enabling keeps
    // the existing cadence. An accepted fall always wins over a due repeat.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        rpt_fire = 1'b0;
        unique case (state_q)
            S_UP: begin
                if (rise) begin
                    state_d = S_DELAY;
                    hold_d  = HOLD_ONE;
                end
            end
            S_DELAY: begin
                if (fall) begin
                    state_d = S_UP;
                    hold_d  = '0;
                end else if (hold_q == HOLD_DELAY) begin
                    rpt_fire = 1'b1;
                    state_d  = S_REPEAT;
                    hold_d   = HOLD_ONE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_REPEAT: begin
                if (fall) begin
                    state_d = S_UP;
                    hold_d  = '0;
                end else if (hold_q == HOLD_PERIOD) begin
                    rpt_fire = 1'b1;
                    hold_d   = HOLD_ONE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = S_UP;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        press_d   = rise;
        release_d = fall;
        rpt_d     = rpt_fire & repeat_en;
        pulse_d   = press_d | rpt_d;
    end

endmodule

// File: rtl/button_pulser.sv
// N-channel button conditioner: independent synchronise/debounce/repeat
// channels between the board push-buttons and the game logic.
module button_pulser
    import button_pulser_pkg::*;
#(
    parameter int N_CH            = 5,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] rpt,
    output logic [N_CH-1:0] pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_pulser_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .in            (in[i]),
            .repeat_en     (repeat_en[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .rpt           (rpt[i]),
            .pulse         (pulse[i])
        );
    end

endmodule

// File: tb/tb_button_pulser.sv
// Directed bench for button_pulser with short debounce/repeat timing.
// Edge k is the k-th rising edge after the scenario stimulus is applied.
module tb_button_pulser;

    localparam int N_CH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] level, press, release_pulse, rpt, pulse;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    button_pulser #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in            (btn),
        .repeat_en     (repeat_en),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .rpt           (rpt),
        .pulse         (pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_level, input logic [1:0] e_press,
                             input logic [1:0] e_rel, input logic [1:0] e_rpt);
        check({tag, ".level"},   32'(level),         32'(e_level));
        check({tag, ".press"},   32'(press),         32'(e_press));
        check({tag, ".release"}, 32'(release_pulse), 32'(e_rel));
        check({tag, ".rpt"},     32'(rpt),           32'(e_rpt));
        check({tag, ".pulse"},   32'(pulse),         32'(e_press | e_rpt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected repeat edge: first at 15, then every 3 edges up to hi.
    function automatic logic rpt_at(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi) && ((k - 15) % 3 == 0);
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        btn       = '0;
        repeat_en = '0;
        tick();
        tick();
        cyc = -1;
        check_all("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] el, ep, er, et;

        // A: press, repeats, release on channel 0.
        do_reset();
        repeat_en = 2'b11;
        btn       = 2'b01;
        for (int k = 0; k <= 45; k++) begin
            if (k == 30) btn[0] = 1'b0;
            tick();
            cyc = k;
            el = {1'b0, (k >= 5 && k < 35)};
            ep = {1'b0, (k == 5)};
            er = {1'b0, (k == 35)};
            et = {1'b0, rpt_at(k, 15, 33)};
            check_all("hold_release", el, ep, er, et);
        end

        // B: channel 1 bouncing every 2 cycles is never accepted.
        do_reset();
        repeat_en = 2'b11;
        for (int k = 0; k <= 47; k++) begin
            btn[1] = (k < 40) ? 1'((k / 2) % 2) : 1'b0;
            tick();
            cyc = k;
            check_all("bounce", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // C: both held; channel 1 repeat enabled late keeps the cadence.
        do_reset();
        repeat_en = 2'b01;
        btn       = 2'b11;
        for (int k = 0; k <= 24; k++) begin
            if (k == 16) repeat_en = 2'b11;
            tick();
            cyc = k;
            el = (k >= 5) ? 2'b11 : 2'b00;
            ep = (k == 5) ? 2'b11 : 2'b00;
            et = {rpt_at(k, 18, 99), rpt_at(k, 15, 99)};
            check_all("repeat_en", el, ep, 2'b00, et);
        end

        // D: reset mid-hold clears everything without a release pulse.
        do_reset();
        repeat_en = 2'b11;
        btn       = 2'b01;
        for (int k = 0; k <= 30; k++) begin
            if (k == 17) rst = 1'b1;
            if (k == 18) rst = 1'b0;
            tick();
            cyc = k;
            el = {1'b0, ((k >= 5 && k < 17) || k >= 23)};
            ep = {1'b0, (k == 5 || k == 23)};
            et = {1'b0, (k == 15)};
            check_all("mid_reset", el, ep, 2'b00, et);
        end

        // E: accepted fall on the edge a repeat is due suppresses the repeat.
        do_reset();
        repeat_en = 2'b01;
        btn       = 2'b01;
        for (int k = 0; k <= 40; k++) begin
            if (k == 31) btn[0] = 1'b0;
            tick();
            cyc = k;
            el = {1'b0, (k >= 5 && k < 36)};
            ep = {1'b0, (k == 5)};
            er = {1'b0, (k == 36)};
            et = {1'b0, rpt_at(k, 15, 33)};
            check_all("fall_vs_rpt", el, ep, er, et);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
